// File: rtl/exc_irq_controller.sv
// rtl/exc_irq_controller.sv - exception/interrupt controller for the single-cycle LEGv8 core
// Edge-latched, maskable, prioritised IRQ lines plus invalid-opcode and double-fault exceptions.
module exc_irq_controller #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic [N_IRQ-1:0] IrqMask,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             ExcAck,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic [N_IRQ-1:0] ExtIAck,
  output logic             InHandler
);

  localparam logic [3:0] CAUSE_NONE   = 4'b0000;
  localparam logic [3:0] CAUSE_IRQ0   = 4'b0001;
  localparam logic [3:0] CAUSE_BADOP  = 4'b0010;
  localparam logic [3:0] CAUSE_DFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKEN   = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [3:0]       cause_q, cause_d;

  logic [2:0]       sel;
  logic             sel_valid;
  logic [2:0]       held_idx;
  logic             held_is_irq;

  logic             exc;
  logic [3:0]       estat;
  logic [N_IRQ-1:0] ack;
  logic             in_hnd;

  function automatic logic [3:0] irq_cause(input logic [2:0] idx);
    return (idx == 3'd0) ? CAUSE_IRQ0 : {1'b1, idx};
  endfunction

  function automatic logic [N_IRQ-1:0] line_onehot(input logic [2:0] idx);
    logic [N_IRQ-1:0] oh;
    for (int k = 0; k < N_IRQ; k++) begin
      oh[k] = (idx == 3'(k));
    end
    return oh;
  endfunction

  // Scanning downward leaves the lowest-index unmasked pending line in sel.
  always_comb begin
    sel       = 3'd0;
    sel_valid = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (pending[k] && !IrqMask[k]) begin
        sel       = 3'(k);
        sel_valid = 1'b1;
      end
    end
  end

  // Recover which line (if any) the latched cause refers to, for the ack in TAKEN.
  always_comb begin
    held_is_irq = cause_q[3] || (cause_q == CAUSE_IRQ0);
    held_idx    = cause_q[3] ? cause_q[2:0] : 3'd0;
  end

  always_comb begin
    state_d = state;
    cause_d = cause_q;
    exc     = 1'b0;
    estat   = CAUSE_NONE;
    ack     = '0;
    in_hnd  = 1'b0;
    case (state)
      IDLE: begin
        if (NotAnInstr) begin
          exc   = 1'b1;
          estat = CAUSE_BADOP;
        end else if (sel_valid) begin
          exc   = 1'b1;
          estat = irq_cause(sel);
          if (ExcAck) begin
            ack = line_onehot(sel);
          end
        end
        if (exc) begin
          cause_d = estat;
          state_d = ExcAck ? HANDLER : TAKEN;
        end
      end
      TAKEN: begin
        exc   = 1'b1;
        estat = cause_q;
        if (ExcAck) begin
          state_d = HANDLER;
          if (held_is_irq) begin
            ack = line_onehot(held_idx);
          end
        end
      end
      HANDLER: begin
        in_hnd = 1'b1;
        if (NotAnInstr) begin
          exc     = 1'b1;
          estat   = CAUSE_DFAULT;
          cause_d = CAUSE_DFAULT;
          state_d = ExcAck ? HANDLER : TAKEN;
        end else if (ERet) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Set wins over the acknowledge clear when both hit the same line in one cycle.
  always_ff @(posedge clk) begin
    irq_q <= ExtIRQ;
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_d;
      cause_q <= cause_d;
      pending <= (pending & ~ack) | (ExtIRQ & ~irq_q);
    end
  end

  assign Exc       = exc & ~reset;
  assign EStatus   = reset ? CAUSE_NONE : estat;
  assign ExtIAck   = reset ? '0 : ack;
  assign InHandler = in_hnd & ~reset;

endmodule

// File: tb/tb_exc_irq_controller.sv
// tb/tb_exc_irq_controller.sv - directed scoreboard bench for exc_irq_controller
module tb_exc_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ext_irq;
  logic [3:0] irq_mask;
  logic       nai;
  logic       eret;
  logic       exc_ack;
  logic       exc;
  logic [3:0] estatus;
  logic [3:0] ext_iack;
  logic       in_handler;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       exc;
    logic [3:0] es;
    logic [3:0] ack;
    logic       inh;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  exc_irq_controller #(.N_IRQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ExtIRQ    (ext_irq),
    .IrqMask   (irq_mask),
    .NotAnInstr(nai),
    .ERet      (eret),
    .ExcAck    (exc_ack),
    .Exc       (exc),
    .EStatus   (estatus),
    .ExtIAck   (ext_iack),
    .InHandler (in_handler)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] irq, input logic [3:0] mask,
                       input logic n, input logic r, input logic a);
    ext_irq  = irq;
    irq_mask = mask;
    nai      = n;
    eret     = r;
    exc_ack  = a;
  endtask

  // Queue the expectation, sample mid-cycle, then retire it against the outputs.
  task automatic step(input string tag, input logic e, input logic [3:0] es,
                      input logic [3:0] a, input logic ih);
    exp_t  obs_v;
    exp_t  exp_v;
    string t;
    exp_q.push_back('{exc: e, es: es, ack: a, inh: ih});
    tag_q.push_back(tag);
    @(negedge clk);
    obs_v = '{exc: exc, es: estatus, ack: ext_iack, inh: in_handler};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed exc/es/ack/inh=%b expected=%b", t, obs_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0001, 4'b0000, 0, 0, 0);
    step("rst_a", 0, 4'b0000, 4'b0000, 0);
    step("rst_b", 0, 4'b0000, 4'b0000, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("high_at_release", 0, 4'b0000, 4'b0000, 0);

    drive(4'b0000, 4'b0000, 0, 0, 0); step("drop0", 0, 4'b0000, 4'b0000, 0);
    drive(4'b0001, 4'b0000, 0, 0, 0); step("edge0_cycle", 0, 4'b0000, 4'b0000, 0);
    step("irq0_exc", 1, 4'b0001, 4'b0000, 0);
    drive(4'b0001, 4'b0000, 0, 0, 1); step("irq0_ack", 1, 4'b0001, 4'b0001, 0);
    drive(4'b0001, 4'b0000, 0, 0, 0); step("irq0_hnd", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0001, 4'b0000, 0, 1, 0); step("irq0_eret", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0001, 4'b0000, 0, 0, 0); step("idle_a", 0, 4'b0000, 4'b0000, 0);

    drive(4'b0111, 4'b0000, 0, 0, 0); step("edge21_cycle", 0, 4'b0000, 4'b0000, 0);
    step("prio_line1", 1, 4'b1001, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 1); step("ack_line1", 1, 4'b1001, 4'b0010, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("hnd_line1", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 1, 0); step("eret_line1", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("back_to_back", 1, 4'b1010, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 1); step("ack_line2", 1, 4'b1010, 4'b0100, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("hnd_line2", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 1, 0); step("eret_line2", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("idle_b", 0, 4'b0000, 4'b0000, 0);

    drive(4'b0110, 4'b0000, 0, 0, 0); step("drop0_b", 0, 4'b0000, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("edge0b_cycle", 0, 4'b0000, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 1, 0, 0); step("badop_over_irq", 1, 4'b0010, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 1); step("badop_ack", 1, 4'b0010, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("badop_hnd", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 1, 0); step("badop_eret", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("pend0_kept", 1, 4'b0001, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 1); step("pend0_ack", 1, 4'b0001, 4'b0001, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("pend0_hnd", 0, 4'b0000, 4'b0000, 1);

    drive(4'b0111, 4'b0000, 1, 0, 0); step("dfault", 1, 4'b0011, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("dfault_hold", 1, 4'b0011, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 1); step("dfault_ack", 1, 4'b0011, 4'b0000, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("dfault_hnd", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 1, 0, 1); step("dfault_same_ack", 1, 4'b0011, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("dfault_stay_hnd", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 1, 0); step("dfault_eret", 0, 4'b0000, 4'b0000, 1);
    drive(4'b0111, 4'b0000, 0, 0, 0); step("idle_c", 0, 4'b0000, 4'b0000, 0);

    drive(4'b1111, 4'b1000, 0, 0, 0); step("edge3_cycle", 0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 10; i++) step("masked3", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("unmask3", 1, 4'b1011, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 1); step("ack_line3", 1, 4'b1011, 4'b1000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("hnd_line3", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1101, 4'b0000, 0, 0, 0); step("hnd_drop1", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("hnd_no_nest", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1111, 4'b0000, 0, 1, 0); step("hnd_eret3", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("latched_in_hnd", 1, 4'b1001, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 1, 0); step("eret_in_taken", 1, 4'b1001, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0);
    reset = 1'b1;                     step("rst_in_taken", 0, 4'b0000, 4'b0000, 0);
    reset = 1'b0;                     step("pending_lost", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 1, 0); step("eret_in_idle", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 1); step("ack_no_exc", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("idle_d", 0, 4'b0000, 4'b0000, 0);

    drive(4'b1101, 4'b0000, 0, 0, 0); step("drop1", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("edge1_cycle", 0, 4'b0000, 4'b0000, 0);
    drive(4'b1111, 4'b0000, 0, 0, 1); step("idle_same_ack", 1, 4'b1001, 4'b0010, 0);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("direct_hnd", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1111, 4'b0000, 0, 1, 0); step("direct_eret", 0, 4'b0000, 4'b0000, 1);
    drive(4'b1111, 4'b0000, 0, 0, 0); step("idle_e", 0, 4'b0000, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_irq_controller.md
# exc_irq_controller

Parametrised exception and interrupt controller for the single-cycle LEGv8 processor; generalises the core's single external interrupt to `N_IRQ` maskable, edge-latched, prioritised lines. Sits beside the main instruction decoder: takes the decoder's invalid-opcode and ERET flags plus the datapath's exception acknowledge, and drives `Exc`, `EStatus` and per-line interrupt acknowledges. Adds pending latches, a handler-active state and double-fault reporting.

## Interface
Parameters:
- `N_IRQ`, 4, number of external interrupt lines; legal range 1..8.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ExtIRQ`  in  N_IRQ  external interrupt request lines; a rising level is latched as pending.
- `IrqMask`  in  N_IRQ  1 = line k blocked from being taken; its pending bit is kept.
- `NotAnInstr`  in  1  decoder flag: current opcode is invalid (synchronous exception).
- `ERet`  in  1  decoder flag: current instruction is ERET.
- `ExcAck`  in  1  datapath has taken the exception (vector loaded).
- `Exc`  out  1  exception request to datapath.
- `EStatus`  out  4  cause code; nonzero only while `Exc` = 1.
- `ExtIAck`  out  N_IRQ  one-hot, one-cycle pulse to the acknowledged line.
- `InHandler`  out  1  1 while an exception handler is running.

## Operation
- State: `irq_q` (previous `ExtIRQ`), `pending[N_IRQ]`, FSM {IDLE, TAKEN, HANDLER}, `cause_q[4]`.
- Edge latch: `pending[k]` set when `ExtIRQ[k] & ~irq_q[k]`; cleared on the edge after `ExtIAck[k]`; set wins if both in same cycle.
- Selection: `sel` = lowest k with `pending[k] & ~IrqMask[k]`; `sel_valid` if any.
- Cause codes: invalid instruction 0010; IRQ line 0 0001; IRQ line k>0 {1'b1, k[2:0]}; double fault 0011; none 0000.
- Priority: NotAnInstr > IRQ; within IRQs, lowest index.
- IDLE: if `NotAnInstr` or `sel_valid`, `Exc` = 1 combinationally with the cause on `EStatus`, `cause_q` loaded. With `ExcAck` same cycle -> HANDLER, else -> TAKEN.
- TAKEN: `Exc` = 1, `EStatus` = `cause_q` (held, new events ignored). `ExcAck` -> HANDLER.
- `ExtIAck[k]` = 1 in the cycle `ExcAck` = 1 and the cause being acknowledged is IRQ k.
- HANDLER: `InHandler` = 1; IRQs not taken (no nesting), pending still latches. `NotAnInstr` -> `Exc` = 1, `EStatus` = 0011, `cause_q` = 0011, -> TAKEN (or stay HANDLER if `ExcAck` same cycle). `ERet` (without `NotAnInstr`) -> IDLE.
- `ERet` outside HANDLER and `ExcAck` while `Exc` = 0 are ignored.

## Timing
- Reset: state IDLE, `pending` = 0, `cause_q` = 0000, `irq_q` loaded with `ExtIRQ` (lines high at release produce no edge). While `reset` = 1 all outputs are 0 combinationally: `Exc` 0, `EStatus` 0000, `ExtIAck` 0, `InHandler` 0.
- Reset mid-operation: aborts TAKEN/HANDLER to IDLE next edge; pending interrupts are lost.
- IRQ latency: edge on `ExtIRQ[k]` at cycle n -> `pending[k]` at n+1 -> `Exc` in cycle n+1 if IDLE and unmasked.
- NotAnInstr latency: zero cycles (combinational `Exc` in the offending instruction's cycle).
- ERet at cycle n -> IDLE at n+1; an unmasked pending IRQ raises `Exc` at n+1 (no extra gap).
- Unmasking a pending line in IDLE raises `Exc` the same cycle.
- Exc held in TAKEN indefinitely until `ExcAck`; `EStatus` stable throughout.

## Test plan
- Reset release with `ExtIRQ` = 4'b0001 held high -> no `Exc` ever; drop and re-raise line 0 -> `Exc` = 1, `EStatus` = 0001 one cycle after the edge.
- Edges on lines 2 and 1 same cycle, `IrqMask` = 0 -> `EStatus` = 1001; `ExcAck` -> `ExtIAck` = 4'b0010; `ERet` -> next cycle `Exc`, `EStatus` = 1010, ack 4'b0100.
- `NotAnInstr` with line 0 pending in IDLE -> `EStatus` = 0010, `ExtIAck` = 0 on ack, line 0 stays pending and is taken after `ERet`.
- In HANDLER, `NotAnInstr` = 1 -> `Exc` = 1, `EStatus` = 0011; `ExcAck` delayed 3 cycles -> `EStatus` held 0011 for all 4 cycles.
- Line 3 pending with `IrqMask[3]` = 1 -> no `Exc` for 10 cycles; clear mask -> `Exc` same cycle, `EStatus` = 1011.
- `reset` asserted in TAKEN -> all outputs 0 that cycle, IDLE and `pending` = 0 after the edge; `ERet` in IDLE -> no effect.
